// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, round helper functions and the
// controller state encoding used by sha256_round and sha256_stream_core.
//   SHA256_H0..H7 / SHA256_IV : initial chaining value
//   SHA256_K[0:63]            : round constants
//   ch, maj, bsig0, bsig1, ssig0, ssig1 : FIPS 180-4 logical functions
//   state_e                   : IDLE, HASH, UPDATE, OUT
package sha256_pkg;

  localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
  localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
  localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
  localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
  localparam logic [31:0] SHA256_H4 = 32'h510e527f;
  localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
  localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
  localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;

  // H0 occupies the most significant word, matching the Digest layout.
  localparam logic [255:0] SHA256_IV = {SHA256_H0, SHA256_H1, SHA256_H2, SHA256_H3,
                                        SHA256_H4, SHA256_H5, SHA256_H6, SHA256_H7};

  localparam logic [31:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, HASH, UPDATE, OUT} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one purely combinational SHA-256 compression round.
//   state_i [255:0] : {a,b,c,d,e,f,g,h}, a in [255:224]
//   w_i     [31:0]  : message schedule word for this round
//   k_i     [31:0]  : round constant for this round
//   state_o [255:0] : {a',b',c',d',e',f',g',h'}
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  w_i,
  input  logic [31:0]  k_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;

  always_comb begin
    t1      = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
    t2      = bsig0(a) + maj(a, b, c);
    state_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: multi-chunk SHA-256 compression engine.
// Accepts pre-padded 512-bit chunks, carries the chaining value between
// chunks of a message and returns the 256-bit digest after the last chunk.
//   Clk, Reset             : clock, asynchronous active-high reset
//   ChunkValid/ChunkReady  : chunk handshake (Chunk, ChunkFirst, ChunkLast)
//   Chunk [511:0]          : padded block, W0 in [511:480]
//   ChunkFirst             : chunk starts a message (chain from IV)
//   ChunkLast              : chunk ends a message (digest produced)
//   DigestValid/DigestReady: digest handshake, Digest [255:0] with H0 in [255:224]
//   Busy                   : high while rounds are being computed
// Parameter ROUNDS_PER_CYCLE (1, 2, 4 or 8) sets rounds computed per clock.
// Optional build macro SHA256_DEBUG_EN adds WOut[31:0] (last W consumed) and
// CurrentHash[255:0] ({a..h} after the cycle's rounds), both registered.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ChunkValid,
  output logic         ChunkReady,
  input  logic [511:0] Chunk,
  input  logic         ChunkFirst,
  input  logic         ChunkLast,
  output logic         DigestValid,
  input  logic         DigestReady,
  output logic [255:0] Digest,
  output logic         Busy
`ifdef SHA256_DEBUG_EN
  ,
  output logic [31:0]  WOut,
  output logic [255:0] CurrentHash
`endif
);

  localparam int ROUND_CYCLES = 64 / ROUNDS_PER_CYCLE;
  localparam int RSHIFT       = $clog2(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_CYC = 6'(ROUND_CYCLES - 1);

  state_e        state_q, state_d;
  logic [5:0]    cyc_q, cyc_d;
  // W window: W[t] sits in [511:480], W[t+15] in [31:0].
  logic [511:0]  w_q, w_d;
  logic [255:0]  vars_q, vars_d;
  logic [255:0]  h_q, h_d;
  logic [255:0]  digest_q, digest_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          dvalid_q, dvalid_d;
  // Holds ChunkReady low until the first clock after reset is released.
  logic          live_q;

  logic [5:0]    round_base;
  logic [255:0]  chain_out;
  logic [511:0]  w_shift;
  logic [32*ROUNDS_PER_CYCLE-1:0] w_new_bus;
  logic [255:0]  h_base;
  logic [255:0]  h_new;

  // First round index handled this cycle; R is a power of two.
  assign round_base = cyc_q << RSHIFT;

  // ---------------------------------------------------------------------------
  // Round chain: ROUNDS_PER_CYCLE combinational rounds back to back.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      logic [255:0] st_in;
      logic [255:0] st_out;
      logic [5:0]   k_idx;
      logic [31:0]  k_word;

      if (gi == 0) begin : g_head
        assign st_in = vars_q;
      end else begin : g_tail
        assign st_in = g_round[gi-1].st_out;
      end

      assign k_idx  = round_base | 6'(gi);
      assign k_word = SHA256_K[k_idx];

      sha256_round u_round (
        .state_i (st_in),
        .w_i     (w_q[511-32*gi -: 32]),
        .k_i     (k_word),
        .state_o (st_out)
      );
    end
  endgenerate

  assign chain_out = g_round[ROUNDS_PER_CYCLE-1].st_out;

  // ---------------------------------------------------------------------------
  // Message schedule: produce W[t+16 .. t+16+R-1]. Later words in the same
  // cycle depend on words produced earlier in this cycle (t-2, t-7 taps).
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_sched
      logic [31:0] wm2, wm7, w_new;

      if (gi >= 2) begin : g_m2_new
        assign wm2 = g_sched[gi-2].w_new;
      end else begin : g_m2_win
        assign wm2 = w_q[511-32*(14+gi) -: 32];
      end

      if (gi >= 7) begin : g_m7_new
        assign wm7 = g_sched[gi-7].w_new;
      end else begin : g_m7_win
        assign wm7 = w_q[511-32*(9+gi) -: 32];
      end

      assign w_new = ssig1(wm2) + wm7 + ssig0(w_q[511-32*(1+gi) -: 32])
                   + w_q[511-32*gi -: 32];
      assign w_new_bus[32*(ROUNDS_PER_CYCLE-1-gi) +: 32] = w_new;
    end
  endgenerate

  assign w_shift = {w_q[511-32*ROUNDS_PER_CYCLE:0], w_new_bus};

  // ---------------------------------------------------------------------------
  // Chaining update: per-word modular add onto IV (first chunk) or H.
  // ---------------------------------------------------------------------------
  assign h_base = first_q ? SHA256_IV : h_q;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_hsum
      assign h_new[32*gi +: 32] = h_base[32*gi +: 32] + vars_q[32*gi +: 32];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign ChunkReady  = live_q && (state_q == IDLE);
  assign Busy        = (state_q == HASH);
  assign DigestValid = dvalid_q;
  assign Digest      = digest_q;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    w_d      = w_q;
    vars_d   = vars_q;
    h_d      = h_q;
    digest_d = digest_q;
    first_d  = first_q;
    last_d   = last_q;
    dvalid_d = dvalid_q;

    case (state_q)
      IDLE: begin
        if (ChunkValid && ChunkReady) begin
          w_d     = Chunk;
          first_d = ChunkFirst;
          last_d  = ChunkLast;
          vars_d  = ChunkFirst ? SHA256_IV : h_q;
          cyc_d   = '0;
          state_d = HASH;
        end
      end
      HASH: begin
        vars_d = chain_out;
        w_d    = w_shift;
        cyc_d  = cyc_q + 6'd1;
        if (cyc_q == LAST_CYC) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        h_d = h_new;
        if (last_q) begin
          digest_d = h_new;
          dvalid_d = 1'b1;
          state_d  = OUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (DigestReady) begin
          dvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      w_q      <= '0;
      vars_q   <= '0;
      h_q      <= SHA256_IV;
      digest_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      dvalid_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      w_q      <= w_d;
      vars_q   <= vars_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      first_q  <= first_d;
      last_q   <= last_d;
      dvalid_q <= dvalid_d;
      live_q   <= 1'b1;
    end
  end

`ifdef SHA256_DEBUG_EN
  logic [31:0]  wout_q, wout_d;
  logic [255:0] cur_hash_q, cur_hash_d;

  always_comb begin
    wout_d     = wout_q;
    cur_hash_d = cur_hash_q;
    if (state_q == HASH) begin
      wout_d     = w_q[511-32*(ROUNDS_PER_CYCLE-1) -: 32];
      cur_hash_d = chain_out;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wout_q     <= '0;
      cur_hash_q <= '0;
    end else begin
      wout_q     <= wout_d;
      cur_hash_q <= cur_hash_d;
    end
  end

  assign WOut        = wout_q;
  assign CurrentHash = cur_hash_q;
`endif

endmodule
